// File: rtl/fir_pkg.sv
// fir_pkg: shared constants, state encoding and mod-NTAPS helpers for the FIR sequencer
package fir_pkg;
  localparam int NTAPS = 15;
  localparam int AW = 4;
  localparam int MAC_LAT = 3;
  typedef enum logic [2:0] {INIT, IDLE, LOAD, RUN, DRAIN, EMIT} state_t;
  typedef struct packed {
    logic samp_read;
    logic dly_wr_en;
    logic dly_zero;
    logic [AW-1:0] dly_wr_addr;
    logic [AW-1:0] tap_addr;
    logic [AW-1:0] coef_rd_addr;
    logic mac_en;
    logic mac_clr;
    logic mac_last;
    logic push_out;
    logic busy;
  } seq_t;
  function automatic logic [AW-1:0] inc_mod(input logic [AW-1:0] a);
    return (a == AW'(NTAPS - 1)) ? '0 : a + 1'b1;
  endfunction
  function automatic logic [AW-1:0] dec_mod(input logic [AW-1:0] a);
    return (a == '0) ? AW'(NTAPS - 1) : a - 1'b1;
  endfunction
endpackage

// File: rtl/fir_tap_ctr.sv
// fir_tap_ctr: mod-NTAPS up-counter with load, enable and terminal-count flag
module fir_tap_ctr import fir_pkg::*; (
  input  logic          clk,
  input  logic          reset,
  input  logic          ld,
  input  logic          en,
  input  logic [AW-1:0] d,
  output logic [AW-1:0] cnt,
  output logic          tc
);
  assign tc = cnt == AW'(NTAPS - 1);
  always_ff @(posedge clk)
    if (!reset) cnt <= '0;
    else if (ld) cnt <= d;
    else if (en) cnt <= inc_mod(cnt);
endmodule

// File: rtl/fir_mac_sched.sv
// fir_mac_sched: time-shares one complex MAC over NTAPS taps per sample and owns the double-buffered coefficient bank
module fir_mac_sched import fir_pkg::*; (
  input  logic          clk,
  input  logic          reset,
  input  logic          samp_valid,
  output logic          samp_read,
  output logic          dly_wr_en,
  output logic          dly_zero,
  output logic [AW-1:0] dly_wr_addr,
  output logic [AW-1:0] tap_addr,
  output logic [AW-1:0] coef_rd_addr,
  output logic          coef_rd_bank,
  output logic          mac_en,
  output logic          mac_clr,
  output logic          mac_last,
  input  logic          push_coef,
  input  logic [4:0]    coef_addr,
  output logic          coef_wr_en,
  output logic [AW-1:0] coef_wr_addr,
  output logic          coef_wr_bank,
  output logic          coef_addr_err,
  input  logic          out_stall,
  output logic          push_out,
  output logic          busy
);
  state_t state, ns;
  seq_t o, n;
  logic go, ld, en, tc, run, swap, ab, ab_n, wr_ok;
  logic [AW-1:0] cnt, d, head, k_n;
  logic [NTAPS-1:0] wr_mask;
  fir_tap_ctr u_ctr (.clk(clk), .reset(reset), .ld(ld), .en(en), .d(d), .cnt(cnt), .tc(tc));
  assign {samp_read, dly_wr_en, dly_zero, dly_wr_addr, tap_addr, coef_rd_addr,
          mac_en, mac_clr, mac_last, push_out, busy} = o;
  assign swap = state == LOAD && &wr_mask;
  assign ab_n = ab ^ swap;
  assign wr_ok = push_coef && coef_addr < 5'(NTAPS);
  // go holds the INIT walk for the one cycle right after reset so it starts at address 0
  always_comb begin
    ns = state;
    ld = 1'b0;
    en = 1'b0;
    d = '0;
    case (state)
      INIT: begin ns = (go && tc) ? IDLE : INIT; en = go && !tc; end
      IDLE: ns = samp_valid ? LOAD : IDLE;
      LOAD: begin ns = RUN; ld = 1'b1; end
      RUN: begin ns = tc ? DRAIN : RUN; ld = tc; en = !tc; d = tc ? AW'(NTAPS - MAC_LAT) : '0; end
      DRAIN: begin ns = tc ? EMIT : DRAIN; en = !tc; end
      EMIT: ns = !o.push_out ? EMIT : samp_valid ? LOAD : IDLE;
      default: ns = INIT;
    endcase
  end
  // outputs are precomputed from the next state so every port is a flop
  always_comb begin
    run = ns == RUN;
    k_n = (state == LOAD) ? '0 : inc_mod(cnt);
    n = '0;
    n.samp_read = ns == LOAD;
    n.dly_wr_en = ns == LOAD || ns == INIT;
    n.dly_zero = ns == INIT;
    n.dly_wr_addr = (ns == LOAD) ? head : (ns == INIT && go) ? inc_mod(cnt) : '0;
    n.tap_addr = !run ? '0 : (state == LOAD) ? head : dec_mod(o.tap_addr);
    n.coef_rd_addr = run ? k_n : '0;
    n.mac_en = run;
    n.mac_clr = run && state == LOAD;
    n.mac_last = run && k_n == AW'(NTAPS - 1);
    n.push_out = ns == EMIT && !out_stall;
    n.busy = ns != IDLE;
  end
  always_ff @(posedge clk)
    if (!reset) begin
      state <= INIT;
      go <= 1'b0;
      o <= '0;
      head <= '0;
      ab <= 1'b0;
      wr_mask <= '0;
      coef_rd_bank <= 1'b0;
      coef_wr_en <= 1'b0;
      coef_wr_addr <= '0;
      coef_wr_bank <= 1'b0;
      coef_addr_err <= 1'b0;
    end else begin
      state <= ns;
      go <= 1'b1;
      o <= n;
      if (state == RUN && tc) head <= inc_mod(head);
      ab <= ab_n;
      wr_mask <= (swap ? '0 : wr_mask) | (NTAPS'(wr_ok) << coef_addr);
      coef_rd_bank <= ab_n;
      coef_wr_en <= wr_ok;
      coef_wr_addr <= wr_ok ? coef_addr[AW-1:0] : '0;
      coef_wr_bank <= wr_ok & ~ab_n;
      coef_addr_err <= push_coef & ~wr_ok;
    end
endmodule

// File: tb/tb_fir_mac_sched.sv
// tb_fir_mac_sched: random and directed stimulus checked every cycle against a queue-based sample-level model
module tb_fir_mac_sched;
  localparam int N = 15;
  localparam int L = 3;
  typedef struct packed {
    logic sr, we, z;
    logic [3:0] wa, ta, ca;
    logic en, clr, last, push, busy;
  } rec_t;
  logic clk = 1'b0, reset, samp_valid, push_coef, out_stall;
  logic [4:0] coef_addr;
  logic samp_read, dly_wr_en, dly_zero, coef_rd_bank, mac_en, mac_clr, mac_last;
  logic coef_wr_en, coef_wr_bank, coef_addr_err, push_out, busy;
  logic [3:0] dly_wr_addr, tap_addr, coef_rd_addr, coef_wr_addr;
  rec_t act, exp_s = '0;
  rec_t q[$];
  int cyc = 0, checks = 0, errors = 0, head = 0, init_n = 0, clr_n = 0, last_n = 0;
  bit em = 0, swp = 0, bank = 0, ecwe = 0, ecwb = 0, eerr = 0;
  logic [3:0] ecwa = '0;
  logic [14:0] mask = '0;
  int sr_q[$], wa_q[$], push_q[$], tap_q[$];

  fir_mac_sched dut (
    .clk(clk), .reset(reset), .samp_valid(samp_valid), .samp_read(samp_read),
    .dly_wr_en(dly_wr_en), .dly_zero(dly_zero), .dly_wr_addr(dly_wr_addr),
    .tap_addr(tap_addr), .coef_rd_addr(coef_rd_addr), .coef_rd_bank(coef_rd_bank),
    .mac_en(mac_en), .mac_clr(mac_clr), .mac_last(mac_last), .push_coef(push_coef),
    .coef_addr(coef_addr), .coef_wr_en(coef_wr_en), .coef_wr_addr(coef_wr_addr),
    .coef_wr_bank(coef_wr_bank), .coef_addr_err(coef_addr_err), .out_stall(out_stall),
    .push_out(push_out), .busy(busy)
  );

  always #5 clk = ~clk;
  assign act = {samp_read, dly_wr_en, dly_zero, dly_wr_addr, tap_addr, coef_rd_addr,
                mac_en, mac_clr, mac_last, push_out, busy};

  function automatic rec_t mk(bit sr, bit we, bit z, int wa, int ta, int ca, bit en, bit clr, bit last);
    rec_t r;
    r = '0;
    r.sr = sr; r.we = we; r.z = z;
    r.wa = 4'(wa); r.ta = 4'(ta); r.ca = 4'(ca);
    r.en = en; r.clr = clr; r.last = last; r.busy = 1'b1;
    return r;
  endfunction

  function automatic int qat(input int qq[$], input int i);
    return (i < qq.size()) ? qq[i] : -1;
  endfunction

  // a sample is one LOAD, NTAPS taps walking backwards from the newest slot, then MAC_LAT quiet cycles
  task automatic start_sample();
    q.push_back(mk(1, 1, 0, head, 0, 0, 0, 0, 0));
    for (int k = 0; k < N; k++) q.push_back(mk(0, 0, 0, 0, (head - k + N) % N, k, 1, k == 0, k == N - 1));
    for (int k = 0; k < L; k++) q.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0));
    head = (head + 1) % N;
    em = 1;
    swp = 1;
  endtask

  task automatic model_step();
    if (!reset) begin
      q.delete();
      for (int i = 0; i < N; i++) q.push_back(mk(0, 1, 1, i, 0, 0, 0, 0, 0));
      q.push_back('0);
      exp_s = '0; em = 0; swp = 0; head = 0; bank = 0; mask = '0;
      ecwe = 0; ecwa = '0; ecwb = 0; eerr = 0;
    end else begin
      if (swp && mask == 15'h7fff) begin bank = ~bank; mask = '0; end
      swp = 0;
      ecwe = push_coef && coef_addr < 5'(N);
      eerr = push_coef && !ecwe;
      ecwa = ecwe ? coef_addr[3:0] : 4'd0;
      ecwb = ecwe && !bank;
      if (ecwe) mask[coef_addr] = 1'b1;
      if (q.size() != 0) exp_s = q.pop_front();
      else if (em) begin exp_s = '0; exp_s.busy = 1'b1; exp_s.push = !out_stall; em = out_stall; end
      else if (samp_valid) begin start_sample(); exp_s = q.pop_front(); end
      else exp_s = '0;
    end
  endtask

  initial forever begin
    @(posedge clk);
    cyc++;
    model_step();
  end

  task automatic chk(input string nm, input int a, input int e);
    checks++;
    if (a != e) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", nm, a, e);
    end
  endtask

  task automatic cmp();
    if (cyc == 0) return;
    checks += 2;
    if (act !== exp_s) begin
      errors++;
      $display("FAIL seq @%0d: got %h expected %h", cyc, act, exp_s);
    end
    if ({coef_wr_en, coef_wr_addr, coef_wr_bank, coef_addr_err, coef_rd_bank} !==
        {ecwe, ecwa, ecwb, eerr, bank}) begin
      errors++;
      $display("FAIL coef @%0d: got %b expected %b", cyc,
               {coef_wr_en, coef_wr_addr, coef_wr_bank, coef_addr_err, coef_rd_bank},
               {ecwe, ecwa, ecwb, eerr, bank});
    end
    if (samp_read) begin sr_q.push_back(cyc); wa_q.push_back(int'(dly_wr_addr)); end
    if (push_out) push_q.push_back(cyc);
    if (mac_en) tap_q.push_back(int'(tap_addr));
    if (mac_clr) clr_n++;
    if (mac_last) last_n++;
    if (dly_wr_en && dly_zero) init_n++;
  endtask

  task automatic step();
    @(negedge clk);
    cmp();
    #2;
  endtask

  task automatic clr_q();
    sr_q.delete(); wa_q.delete(); push_q.delete(); tap_q.delete();
    clr_n = 0; last_n = 0; init_n = 0;
  endtask

  task automatic wait_sr(input int cnt, input int budget);
    while (sr_q.size() < cnt && budget > 0) begin step(); budget--; end
    chk("sr_wait", int'(sr_q.size() >= cnt), 1);
  endtask

  initial begin
    int s, rel, b;
    reset = 0; samp_valid = 0; push_coef = 0; coef_addr = '0; out_stall = 0;
    repeat (3) step();
    chk("rst_outs", int'(act), 0);
    clr_q();
    reset = 1;
    repeat (17) step();
    chk("init_cnt", init_n, 15);
    chk("init_then_idle", int'(busy), 0);
    // single sample
    clr_q();
    samp_valid = 1; step(); samp_valid = 0;
    repeat (24) step();
    chk("one_sr", sr_q.size(), 1);
    chk("one_wa", qat(wa_q, 0), 0);
    chk("one_push_n", push_q.size(), 1);
    chk("one_lat", qat(push_q, 0) - qat(sr_q, 0), 19);
    chk("one_taps", tap_q.size(), 15);
    chk("one_tap0", qat(tap_q, 0), 0);
    chk("one_tap1", qat(tap_q, 1), 14);
    chk("one_tap14", qat(tap_q, 14), 1);
    chk("one_clr", clr_n, 1);
    chk("one_last", last_n, 1);
    // back-to-back samples with delay-line wrap
    clr_q();
    samp_valid = 1;
    wait_sr(17, 400);
    samp_valid = 0;
    repeat (25) step();
    chk("sus_push_n", push_q.size(), 17);
    chk("sus_period", qat(push_q, 16) - qat(push_q, 0), 320);
    chk("sus_wrap", qat(wa_q, 14), 0);
    chk("sus_wa16", qat(wa_q, 16), 2);
    // output stall with a pending sample
    clr_q();
    out_stall = 1; samp_valid = 1;
    wait_sr(1, 40);
    s = qat(sr_q, 0);
    b = 40;
    while (cyc < s + 23 && b > 0) begin step(); b--; end
    out_stall = 0;
    wait_sr(2, 10);
    samp_valid = 0;
    repeat (25) step();
    chk("stall_lat", qat(push_q, 0) - s, 24);
    chk("stall_next_sr", qat(sr_q, 1) - qat(push_q, 0), 1);
    chk("stall_pulses", push_q.size(), 2);
    // partial coefficient set never swaps
    for (int a = 0; a < 14; a++) begin push_coef = 1; coef_addr = 5'(a); step(); end
    push_coef = 0;
    clr_q();
    samp_valid = 1;
    wait_sr(2, 60);
    samp_valid = 0;
    repeat (25) step();
    chk("no_swap_bank", int'(coef_rd_bank), 0);
    // completing the set swaps at the next LOAD; a write in that LOAD hits the old bank
    push_coef = 1; coef_addr = 5'd14; step(); push_coef = 0;
    clr_q();
    samp_valid = 1;
    wait_sr(1, 40);
    push_coef = 1; coef_addr = 5'd3; samp_valid = 0;
    step();
    chk("co_we", int'(coef_wr_en), 1);
    chk("co_bank", int'(coef_wr_bank), 0);
    chk("swap_bank", int'(coef_rd_bank), 1);
    coef_addr = 5'd20;
    step();
    chk("err_pulse", int'(coef_addr_err), 1);
    chk("err_nowr", int'(coef_wr_en), 0);
    push_coef = 0;
    step();
    chk("err_once", int'(coef_addr_err), 0);
    repeat (25) step();
    // random traffic
    for (int i = 0; i < 1500; i++) begin
      samp_valid = $urandom_range(0, 3) != 0;
      out_stall = $urandom_range(0, 3) == 0;
      push_coef = $urandom_range(0, 2) == 0;
      coef_addr = ($urandom_range(0, 4) == 0) ? 5'($urandom_range(15, 31)) : 5'($urandom_range(0, 14));
      step();
    end
    // reset in the middle of a sample
    push_coef = 0; out_stall = 0; samp_valid = 1;
    b = 100;
    while (!(mac_en && coef_rd_addr == 4'd7) && b > 0) begin step(); b--; end
    chk("k7_wait", int'(mac_en && coef_rd_addr == 4'd7), 1);
    reset = 0;
    step();
    clr_q();
    reset = 1;
    rel = cyc;
    wait_sr(1, 40);
    chk("rr_sr", qat(sr_q, 0) - rel, 17);
    chk("rr_wa", qat(wa_q, 0), 0);
    chk("rr_bank", int'(coef_rd_bank), 0);
    chk("rr_nopush", push_q.size(), 0);
    chk("rr_init", init_n, 15);
    samp_valid = 0;
    repeat (25) step();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
